// File: rtl/fta_bus_pkg.sv
// Shared FTA bus definitions: response codes, command codes and the
// state encoding of the FTA-to-Wishbone responder bridge.
package fta_bus_pkg;

    typedef enum logic [1:0] {
        OKAY    = 2'b00,
        DECERR  = 2'b01,
        PROTERR = 2'b10,
        ERR     = 2'b11
    } fta_err_t;

    typedef enum logic [3:0] {
        CMD_NONE  = 4'd0,
        CMD_LOAD  = 4'd1,
        CMD_STORE = 4'd2
    } fta_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RETRY = 2'd2,
        RESP  = 2'd3
    } fta_to_wb_state_e;

endpackage

// File: rtl/fta_bus_interface.sv
// FTA bus: a single-cycle request pulse from the master and a response
// (with stall back-pressure) from the slave.
interface fta_bus_interface #(
    parameter int WID = 256
);
    import fta_bus_pkg::*;

    typedef struct packed {
        logic             cyc;
        logic             we;
        logic [7:0]       tid;
        logic [5:0]       blen;
        logic [WID/8-1:0] sel;
        logic [31:0]      adr;
        logic [WID-1:0]   data1;
    } req_t;

    typedef struct packed {
        logic [7:0]     tid;
        logic           stall;
        logic           ack;
        fta_err_t       err;
        logic [31:0]    adr;
        logic [WID-1:0] dat;
    } resp_t;

    req_t  req;
    resp_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);

endinterface

// File: rtl/fta_req_fifo.sv
// Synchronous FIFO holding captured FTA requests; a push while full and a
// pop while empty are ignored.
module fta_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fta_to_wb_bridge.sv
// FTA slave to classic Wishbone master bridge: buffers requests, replays
// each as one or more WB beats and answers with the original tid.
module fta_to_wb_bridge
    import fta_bus_pkg::*;
#(
    parameter int WID     = 256,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023,
    parameter int RETRIES = 100
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cs_i,
    fta_bus_interface.slave  fta_i,
    output logic             cyc_o,
    output logic             stb_o,
    output logic             we_o,
    output logic [WID/8-1:0] sel_o,
    output logic [31:0]      adr_o,
    output logic [WID-1:0]   dat_o,
    input  logic [WID-1:0]   dat_i,
    input  logic             ack_i,
    input  logic             err_i,
    input  logic             rty_i
);
    localparam int SELW = WID/8;
    localparam int CW   = $clog2(DEPTH+1);
    localparam int TW   = $clog2(TIMEOUT+1);
    localparam int RW   = $clog2(RETRIES+1);

    typedef struct packed {
        logic [7:0]      tid;
        logic            we;
        logic [SELW-1:0] sel;
        logic [31:0]     adr;
        logic [5:0]      blen;
        logic [WID-1:0]  data;
    } entry_t;

    entry_t           in_entry;
    entry_t           out_entry;
    entry_t           hold;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic [CW-1:0]    occ_n;
    logic             stall_q;

    fta_to_wb_state_e state;
    fta_to_wb_state_e state_n;
    logic [5:0]       beat;
    logic [TW-1:0]    tmo_cnt;
    logic [RW-1:0]    rty_cnt;
    fta_err_t         resp_err;
    logic [WID-1:0]   rdat;
    logic [31:0]      beat_adr;
    logic             fin_ok;
    logic             fin_err;
    logic             go_retry;

    assign in_entry = '{tid:  fta_i.req.tid,
                        we:   fta_i.req.we,
                        sel:  fta_i.req.sel,
                        adr:  fta_i.req.adr,
                        blen: fta_i.req.blen,
                        data: fta_i.req.data1};

    assign push  = fta_i.req.cyc && cs_i && !full;
    assign pop   = (state == IDLE) && !empty;
    assign occ_n = count + CW'(push) - CW'(pop);

    fta_req_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push),
        .pop   (pop),
        .din   (in_entry),
        .dout  (out_entry),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign beat_adr = hold.adr + 32'(beat) * 32'(SELW);

    always_comb begin
        state_n  = state;
        fin_ok   = 1'b0;
        fin_err  = 1'b0;
        go_retry = 1'b0;
        cyc_o    = 1'b0;
        stb_o    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) state_n = ISSUE;
            end
            ISSUE: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                if (err_i) begin
                    fin_err = 1'b1;
                    state_n = RESP;
                end else if (ack_i) begin
                    fin_ok  = 1'b1;
                    state_n = RESP;
                end else if (rty_i) begin
                    if (rty_cnt == RW'(RETRIES)) begin
                        fin_err = 1'b1;
                        state_n = RESP;
                    end else begin
                        go_retry = 1'b1;
                        state_n  = RETRY;
                    end
                end else if (tmo_cnt == TW'(TIMEOUT)) begin
                    fin_err = 1'b1;
                    state_n = RESP;
                end
            end
            RETRY: begin
                state_n = ISSUE;
            end
            RESP: begin
                // Keep the WB cycle open only when another burst beat follows.
                if (resp_err == OKAY && beat < hold.blen) begin
                    cyc_o   = 1'b1;
                    state_n = ISSUE;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE;
            beat     <= '0;
            tmo_cnt  <= '0;
            rty_cnt  <= '0;
            resp_err <= OKAY;
            stall_q  <= 1'b0;
        end else begin
            state   <= state_n;
            stall_q <= (occ_n >= CW'(DEPTH-1));
            unique case (state)
                IDLE: begin
                    if (pop) beat <= '0;
                end
                ISSUE: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (fin_ok)   resp_err <= OKAY;
                    if (fin_err)  resp_err <= ERR;
                    if (go_retry) rty_cnt  <= rty_cnt + RW'(1);
                end
                RETRY: begin
                    tmo_cnt <= '0;
                end
                RESP: begin
                    tmo_cnt <= '0;
                    rty_cnt <= '0;
                    if (state_n == ISSUE) beat <= beat + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // Stores are forced single-beat by zeroing the held burst length.
    always_ff @(posedge clk_i) begin
        if (pop) begin
            hold <= out_entry;
            if (out_entry.we) hold.blen <= '0;
        end
        if (fin_ok)       rdat <= dat_i;
        else if (fin_err) rdat <= '0;
    end

    always_comb begin
        we_o  = (state == ISSUE) && hold.we;
        sel_o = (state == ISSUE) ? hold.sel  : '0;
        adr_o = (state == ISSUE) ? beat_adr  : '0;
        dat_o = (state == ISSUE) ? hold.data : '0;
    end

    always_comb begin
        fta_i.resp       = '0;
        fta_i.resp.stall = stall_q;
        if (state == RESP) begin
            fta_i.resp.ack = 1'b1;
            fta_i.resp.tid = hold.tid;
            fta_i.resp.adr = beat_adr;
            fta_i.resp.err = resp_err;
            fta_i.resp.dat = hold.we ? '0 : rdat;
        end
    end

endmodule

// File: tb/tb_fta_to_wb_bridge.sv
// Bench for fta_to_wb_bridge: directed scenarios plus randomized traffic
// checked against a transaction-level scoreboard.
module tb_fta_to_wb_bridge;
    import fta_bus_pkg::*;

    localparam int WID     = 256;
    localparam int SELW    = WID/8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 1023;
    localparam int RETRIES = 100;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            cs_i;
    logic            cyc_o, stb_o, we_o;
    logic [SELW-1:0] sel_o;
    logic [31:0]     adr_o;
    logic [WID-1:0]  dat_o;
    logic [WID-1:0]  dat_i;
    logic            ack_i, err_i, rty_i;
    logic            ack_q;

    fta_bus_interface #(.WID(WID)) fta ();

    fta_to_wb_bridge #(
        .WID(WID), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .RETRIES(RETRIES)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .cs_i(cs_i), .fta_i(fta),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o),
        .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i),
        .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]     tid;
        logic [31:0]    adr;
        logic [WID-1:0] dat;
        fta_err_t       err;
        logic           chk_dat;
    } exp_resp_t;

    typedef struct packed {
        logic            we;
        logic [31:0]     adr;
        logic [SELW-1:0] sel;
        logic [WID-1:0]  dat;
    } exp_wb_t;

    exp_resp_t rq[$];
    exp_wb_t   wq[$];

    int n_chk  = 0;
    int n_fail = 0;

    // WB responder behaviour: 0 ack, 1 err on beat err_beat, 2 always retry,
    // 3 never answer, 4 hold off (never answer until changed).
    int rsp_mode  = 0;
    int rsp_dly   = 0;
    int wait_cnt  = 0;
    int err_beat  = 0;
    int ack_beats = 0;
    bit rnd_dly   = 0;
    bit fixed_dat = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WID-1:0] rd_pat(input logic [31:0] a);
        return {8{a ^ 32'hDEAD_BEEF}};
    endfunction

    function automatic logic [WID-1:0] rnd256();
        logic [WID-1:0] r;
        for (int i = 0; i < WID/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Scoreboard entries for a request whose beats are all acknowledged.
    task automatic model(input logic [7:0] tid, input logic we, input logic [SELW-1:0] sel,
                         input logic [31:0] adr, input logic [5:0] blen, input logic [WID-1:0] data);
        int nb;
        logic [31:0] a;
        logic [WID-1:0] rd;
        nb = we ? 1 : int'(blen) + 1;
        for (int b = 0; b < nb; b++) begin
            a  = adr + 32'(b * SELW);
            rd = fixed_dat ? {32{8'hA5}} : rd_pat(a);
            wq.push_back('{we: we, adr: a, sel: sel, dat: data});
            rq.push_back('{tid: tid, adr: a, dat: we ? {WID{1'b0}} : rd, err: OKAY, chk_dat: 1'b1});
        end
    endtask

    task automatic send(input logic sel_cs, input logic [7:0] tid, input logic we,
                        input logic [SELW-1:0] sel, input logic [31:0] adr,
                        input logic [5:0] blen, input logic [WID-1:0] data);
        cs_i            = sel_cs;
        fta.req.cyc     = 1'b1;
        fta.req.tid     = tid;
        fta.req.we      = we;
        fta.req.sel     = sel;
        fta.req.adr     = adr;
        fta.req.blen    = blen;
        fta.req.data1   = data;
        @(negedge clk);
        fta.req.cyc     = 1'b0;
        cs_i            = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((rq.size() != 0 || cyc_o) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 256'(n < 3000), 256'(1));
        repeat (3) @(negedge clk);
        chk({tag, "_wb_beats_left"}, 256'(wq.size()), 256'(0));
    endtask

    always @(posedge clk) ack_q <= ack_i;

    // WB peripheral model.
    initial begin
        exp_wb_t w;
        ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; dat_i = '0;
        forever begin
            @(negedge clk);
            ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
            if (rst_ni && cyc_o && stb_o) begin
                if (wait_cnt < rsp_dly) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    if (rsp_mode == 2) begin
                        rty_i = 1'b1;
                    end else if (rsp_mode == 1 && ack_beats == err_beat) begin
                        err_i = 1'b1;
                    end else if (rsp_mode <= 1) begin
                        if (wq.size() == 0) begin
                            chk("wb_beat_expected", 256'(wq.size()), 256'(1));
                        end else begin
                            w = wq.pop_front();
                            chk("wb_adr", 256'(adr_o), 256'(w.adr));
                            chk("wb_we", 256'(we_o), 256'(w.we));
                            if (w.we) begin
                                chk("wb_sel", 256'(sel_o), 256'(w.sel));
                                chk("wb_dat", dat_o, w.dat);
                            end
                        end
                        dat_i = fixed_dat ? {32{8'hA5}} : rd_pat(adr_o);
                        ack_i = 1'b1;
                        ack_beats++;
                        if (rnd_dly) rsp_dly = $urandom_range(0, 3);
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // FTA response scoreboard.
    initial begin
        exp_resp_t r;
        forever begin
            @(negedge clk);
            if (fta.resp.ack) begin
                if (rq.size() == 0) begin
                    chk("resp_expected", 256'(rq.size()), 256'(1));
                end else begin
                    r = rq.pop_front();
                    chk("resp_tid", 256'(fta.resp.tid), 256'(r.tid));
                    chk("resp_adr", 256'(fta.resp.adr), 256'(r.adr));
                    chk("resp_err", 256'(fta.resp.err), 256'(r.err));
                    if (r.chk_dat) chk("resp_dat", fta.resp.dat, r.dat);
                    if (r.err == OKAY) chk("resp_after_ack", 256'(ack_q), 256'(1));
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lows, acks, exp_occ;
        bit started, seen;
        logic c, we;
        logic [5:0] bl;
        logic [31:0] a;

        rst_ni = 1'b0;
        cs_i   = 1'b0;
        fta.req = '0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", 256'(cyc_o), 256'(0));
        chk("rst_stb", 256'(stb_o), 256'(0));
        chk("rst_we", 256'(we_o), 256'(0));
        chk("rst_adr", 256'(adr_o), 256'(0));
        chk("rst_sel", 256'(sel_o), 256'(0));
        chk("rst_resp_ack", 256'(fta.resp.ack), 256'(0));
        chk("rst_resp_stall", 256'(fta.resp.stall), 256'(0));
        chk("rst_resp_err", 256'(fta.resp.err), 256'(OKAY));
        rst_ni = 1'b1;
        @(negedge clk);

        // Single load with fixed read data and a 3-cycle WB wait.
        fixed_dat = 1; rsp_mode = 0; rsp_dly = 3; rnd_dly = 0;
        model(8'h41, 1'b0, '1, 32'h1000_0040, 6'd0, '0);
        send(1'b1, 8'h41, 1'b0, '1, 32'h1000_0040, 6'd0, '0);
        chk("load_cyc_n1", 256'(cyc_o), 256'(0));
        @(negedge clk);
        chk("load_cyc_n2", 256'(cyc_o), 256'(1));
        wait_done("load_done");
        fixed_dat = 0;

        // Single store; blen is ignored.
        rsp_dly = 1;
        model(8'h42, 1'b1, 32'h0000_00FF, 32'h1000_0100, 6'd0, 256'h1234);
        send(1'b1, 8'h42, 1'b1, 32'h0000_00FF, 32'h1000_0100, 6'd5, 256'h1234);
        @(negedge clk);
        chk("store_we", 256'(we_o), 256'(1));
        chk("store_sel", 256'(sel_o), 256'h0000_00FF);
        chk("store_dat", dat_o, 256'h1234);
        wait_done("store_done");

        // Burst load of four beats; cycle must stay asserted throughout.
        rsp_dly = 0;
        model(8'h43, 1'b0, '1, 32'h0000_2000, 6'd3, '0);
        send(1'b1, 8'h43, 1'b0, '1, 32'h0000_2000, 6'd3, '0);
        started = 0; acks = 0; lows = 0; n = 0;
        while (acks < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (cyc_o) started = 1;
            if (fta.resp.ack) acks++;
            else if (started && !cyc_o) lows++;
        end
        chk("burst_acks", 256'(acks), 256'(4));
        chk("burst_cyc_gaps", 256'(lows), 256'(0));
        wait_done("burst_done");

        // Error on beat 1 of a four-beat burst ends the burst.
        rsp_mode = 1; err_beat = 1; ack_beats = 0; rsp_dly = 1;
        wq.push_back('{we: 1'b0, adr: 32'h3000, sel: '1, dat: '0});
        rq.push_back('{tid: 8'h44, adr: 32'h3000, dat: rd_pat(32'h3000), err: OKAY, chk_dat: 1'b1});
        rq.push_back('{tid: 8'h44, adr: 32'h3020, dat: '0, err: ERR, chk_dat: 1'b0});
        send(1'b1, 8'h44, 1'b0, '1, 32'h0000_3000, 6'd3, '0);
        n = 0;
        while (!(fta.resp.ack && fta.resp.err == ERR) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("err_seen", 256'(n < 100), 256'(1));
        chk("err_cyc_low", 256'(cyc_o), 256'(0));
        repeat (6) @(negedge clk);
        chk("err_beats_acked", 256'(ack_beats), 256'(1));
        chk("err_cyc_stays_low", 256'(cyc_o), 256'(0));
        wait_done("err_done");

        // Permanent retry: RETRIES single-cycle gaps, then an error.
        rsp_mode = 2; rsp_dly = 0;
        rq.push_back('{tid: 8'h45, adr: 32'h5000, dat: '0, err: ERR, chk_dat: 1'b0});
        send(1'b1, 8'h45, 1'b0, '1, 32'h0000_5000, 6'd0, '0);
        started = 0; lows = 0; n = 0;
        while (!fta.resp.ack && n < 2000) begin
            @(negedge clk);
            n++;
            if (cyc_o) started = 1;
            else if (started && !fta.resp.ack) lows++;
        end
        chk("rty_gaps", 256'(lows), 256'(RETRIES));
        wait_done("rty_done");

        // Silent peripheral: error TIMEOUT+1 cycles after cyc_o rises.
        rsp_mode = 3;
        rq.push_back('{tid: 8'h46, adr: 32'h6000, dat: '0, err: ERR, chk_dat: 1'b0});
        send(1'b1, 8'h46, 1'b0, '1, 32'h0000_6000, 6'd0, '0);
        n = 0;
        while (!cyc_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cyc_rise", 256'(cyc_o), 256'(1));
        n = 0;
        while (!fta.resp.ack && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_latency", 256'(n), 256'(TIMEOUT + 1));
        wait_done("tmo_done");

        // Six back-to-back requests against a stalled peripheral: one is
        // in service, DEPTH are queued, the last one is dropped.
        rsp_mode = 4;
        for (int k = 0; k <= DEPTH; k++)
            model(8'h60 + 8'(k), 1'b0, '1, 32'h4000 + 32'(k * 256), 6'd0, '0);
        for (int k = 0; k < 6; k++) begin
            cs_i          = 1'b1;
            fta.req.cyc   = 1'b1;
            fta.req.tid   = 8'h60 + 8'(k);
            fta.req.we    = 1'b0;
            fta.req.sel   = '1;
            fta.req.adr   = 32'h4000 + 32'(k * 256);
            fta.req.blen  = 6'd0;
            fta.req.data1 = '0;
            @(negedge clk);
            exp_occ = ((k + 1 < DEPTH + 1) ? k + 1 : DEPTH + 1) - 1;
            chk($sformatf("stall_after_req%0d", k), 256'(fta.resp.stall), 256'(exp_occ >= DEPTH - 1));
        end
        fta.req.cyc = 1'b0;
        cs_i = 1'b0;
        repeat (4) @(negedge clk);
        rsp_mode = 0; rnd_dly = 1;
        wait_done("fill_drain");
        chk("fill_stall_released", 256'(fta.resp.stall), 256'(0));

        // Randomized traffic honouring stall; some requests are unselected.
        for (int i = 0; i < 40; i++) begin
            c  = ($urandom_range(0, 7) != 0);
            we = $urandom_range(0, 1) == 1;
            bl = 6'($urandom_range(0, 3));
            a  = $urandom;
            n = 0;
            while (fta.resp.stall && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (c) model(8'(i), we, SELW'($urandom), a, bl, rnd256());
            if (c) begin
                send(1'b1, 8'(i), we, wq[wq.size()-1].sel, a, bl, wq[wq.size()-1].dat);
            end else begin
                send(1'b0, 8'(i), we, '1, a, bl, '0);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_done("random_done");

        // Reset in the middle of an access with another request queued.
        rsp_mode = 4; rnd_dly = 0; rsp_dly = 0;
        send(1'b1, 8'h70, 1'b0, '1, 32'h7000, 6'd2, '0);
        send(1'b1, 8'h71, 1'b1, '1, 32'h7100, 6'd0, 256'h55);
        n = 0;
        while (!cyc_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        rst_ni = 1'b0;
        @(negedge clk);
        chk("midrst_cyc", 256'(cyc_o), 256'(0));
        chk("midrst_stb", 256'(stb_o), 256'(0));
        chk("midrst_we", 256'(we_o), 256'(0));
        chk("midrst_adr", 256'(adr_o), 256'(0));
        chk("midrst_dat", dat_o, 256'(0));
        chk("midrst_resp_ack", 256'(fta.resp.ack), 256'(0));
        chk("midrst_resp_stall", 256'(fta.resp.stall), 256'(0));
        rst_ni = 1'b1;
        rsp_mode = 0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (cyc_o) seen = 1;
        end
        chk("midrst_fifo_flushed", 256'(seen), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fta_to_wb_bridge.md
Name: fta_to_wb_bridge

Overview:
Responder-side bridge. It accepts FTA bus requests as a slave and replays them as classic Wishbone master cycles toward legacy WB peripherals, then returns FTA responses carrying the original tid. Incoming requests are buffered in a small FIFO because FTA requests are single-cycle pulses with only stall back-pressure. Read bursts (blen>0) are split into blen+1 WB beats.

Parameters:
WID, 256, data width in bits; sel width is WID/8.
DEPTH, 4, request FIFO depth (power of two, at least 2).
TIMEOUT, 1023, cycles without ack_i/err_i/rty_i before an access is abandoned.
RETRIES, 100, WB rty_i count before an error is reported.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  synchronous, active-low reset.
cs_i  in  1  bridge selected; qualifies fta_i.req.cyc.
fta_i  modport  fta_bus_interface.slave  request in (req), response out (resp).
cyc_o  out  1  WB cycle.
stb_o  out  1  WB strobe.
we_o  out  1  WB write enable.
sel_o  out  WID/8  WB byte selects.
adr_o  out  32  WB address.
dat_o  out  WID  WB write data.
dat_i  in  WID  WB read data.
ack_i  in  1  WB acknowledge.
err_i  in  1  WB error.
rty_i  in  1  WB retry.

Behaviour:
- Reset (rst_ni low at a clock edge): all WB outputs are 0. fta_i.resp is cleared to 0 (stall=0, ack=0, err=OKAY). FIFO is flushed. State goes to IDLE, and the beat, retry and timeout counters are cleared. The same applies mid-transaction: the cycle is dropped with no response.
- Accept: when fta_i.req.cyc & cs_i & !full, push {tid, we, sel, adr, blen, data1}. A push while full is discarded.
- resp.stall is registered and high while FIFO occupancy is at least DEPTH-1. The one-cycle-early assertion absorbs a request already in flight, so a master that honours stall never overflows the FIFO.
- Stores ignore blen and are always single-beat.
- State machine:
  - IDLE: if the FIFO is not empty, pop into the hold registers, set beat=0, and go to ISSUE.
  - ISSUE: cyc_o=stb_o=1. adr_o = adr + beat*(WID/8), 32-bit wrap. we_o/sel_o/dat_o come from the hold registers. The timeout counter increments each cycle.
    - ack_i: capture dat_i and go to RESP (ok).
    - err_i: go to RESP (err).
    - rty_i: increment rty_cnt and go to RETRY. If rty_cnt reaches RETRIES, go to RESP (err) instead.
    - Timeout counter == TIMEOUT: go to RESP (err).
    - Simultaneous inputs resolve with priority err_i > ack_i > rty_i.
  - RETRY: stb_o=0 and cyc_o=0 for exactly one cycle, then back to ISSUE. The timeout counter resets; rty_cnt is retained.
  - RESP: stb_o=0 and cyc_o stays high. Drive a one-cycle response: resp.ack=1, resp.tid=held tid, resp.adr=beat address, resp.dat=captured data (0 for stores), resp.err=OKAY or ERR. Clear the timeout counter and rty_cnt.
    - If ok and beat<blen: beat+1 and go to ISSUE.
    - Otherwise: cyc_o=0 and go to IDLE.
  - An error terminates the remainder of a burst.
- Latency: with the FIFO empty and the bridge in IDLE, a request sampled at edge n gives cyc_o at n+2. ack_i sampled at edge m gives resp.ack at m+1. Back-to-back transactions insert one IDLE cycle with cyc_o low.
- Pushes and pops in the same cycle are legal, and occupancy is unchanged.

Decomposition:
- fta_bus_pkg gains the typedef fta_to_wb_state_e (IDLE, ISSUE, RETRY, RESP).
- Existing OKAY/ERR and CMD codes are reused from fta_bus_pkg.
- Sub-module fta_req_fifo: a synchronous FIFO with push, pop, full, empty and count, parameterised on entry width and DEPTH.

Test Plan:
1. Single load, adr=0x1000_0040, tid=0x41. WB acks after 3 cycles with dat=0xA5..A5. Expect one resp.ack with tid=0x41, adr=0x1000_0040, dat=0xA5..A5, err=OKAY.
2. Single store, sel=0x0000_00FF, data1=0x1234. Check we_o=1, sel_o and dat_o match. Expect one resp.ack with dat=0 and err=OKAY.
3. Burst load, blen=3, adr=0x2000. Expect adr_o sequence 0x2000, 0x2020, 0x2040, 0x2060 (WID=256). Expect four resp.acks with matching adr, and cyc_o continuous across the burst.
4. Respond with err_i on beat 1 of a blen=3 load. Expect resp ERR for beat 1, no further beats, and cyc_o low next cycle.
5. Two cases on separate requests:
   - Hold rty_i every access. Expect exactly 100 one-cycle cyc_o gaps, then resp ERR.
   - Never ack. Expect resp ERR TIMEOUT+1 cycles after cyc_o rises.
6. Issue 6 back-to-back requests while WB ack is stalled, with DEPTH=4. Expect stall to rise once occupancy reaches 3. Then release acks and expect all accepted tids returned in order. Assert rst_ni low mid-cycle and expect all outputs 0 next edge.
